// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC, one outstanding imem request, DEPTH-entry queue toward decode.
// Ack in cycle N is visible on id_* in N+1; no request issues while full. `FETCH_STATS_EN adds a stall counter.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e        state_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   fetch_pc_q;

  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_pop;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_instr_q, id_instr_d;

  logic          push;
  logic          pop;
  logic [31:0]   fetch_pc_inc;

  assign push            = (state_q == REQ) && imem_ack_i && !redirect_i;
  assign pop             = (count_q != '0) && id_ready_i && !redirect_i;
  assign count_after_pop = count_q - CW'(pop);
  assign fetch_pc_inc    = fetch_pc_q + 32'd4;

  // id_* are registered copies of the head so they hold their last value once the queue drains.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_after_pop + CW'(push);
      if (count_after_pop != '0) begin
        id_pc_d    = mem_pc_q[rd_ptr_d];
        id_instr_d = mem_instr_q[rd_ptr_d];
      end else if (push) begin
        id_pc_d    = fetch_pc_q;
        id_instr_d = imem_instr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
      mem_instr_q[wr_ptr_q] <= imem_instr_i;
    end
  end

  // A redirect while a request is outstanding cannot cancel it; DROP waits for and discards its ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (redirect_i) fetch_pc_q <= redirect_pc_i & ~32'h3;
      case (state_q)
        IDLE: begin
          if (!redirect_i && start_i && (count_q < CW'(DEPTH))) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            if (redirect_i) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else begin
              fetch_pc_q <= fetch_pc_inc;
              if (start_i && (count_d < CW'(DEPTH))) begin
                addr_q <= fetch_pc_inc;
              end else begin
                state_q <= IDLE;
                req_q   <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign id_valid_o  = (count_q != '0);
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign id_pc4_o    = id_pc_q + 32'd4;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (id_ready_i && (count_q == '0)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst, start, ack, redir, rdy;
  logic [31:0] instr, rpc;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc, id_pc4, stall_cnt;

  always #5 clk = ~clk;

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (ack),
    .imem_instr_i (instr),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .id_valid_o   (id_valid),
    .id_ready_i   (rdy),
    .id_instr_o   (id_instr),
    .id_pc_o      (id_pc),
    .id_pc4_o     (id_pc4),
    .stall_cnt_o  (stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  // Reference model: queue contents, the single outstanding request, and whether its data is doomed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  bit          m_req, m_drop, m_addr_known;
  logic [31:0] m_fpc, m_addr, m_lpc, m_lins, m_stall;

  task automatic model_reset();
    q.delete();
    m_req        = 0;
    m_drop       = 0;
    m_addr_known = 1;
    m_fpc        = RPC;
    m_addr       = RPC;
    m_lpc        = 0;
    m_lins       = 0;
    m_stall      = 0;
  endtask

  task automatic model_step();
    int size_before;
    if (rst) begin
      model_reset();
      return;
    end
    size_before = q.size();
    if (rdy && size_before == 0) m_stall = m_stall + 1;
    if (redir) begin
      q.delete();
      m_fpc = rpc & ~32'h3;
      if (m_req) begin
        if (ack) begin
          m_req  = 0;
          m_drop = 0;
        end else begin
          m_drop = 1;
        end
      end
    end else begin
      if (size_before != 0 && rdy) void'(q.pop_front());
      if (m_req && ack) begin
        m_req = 0;
        if (!m_drop) begin
          q.push_back('{pc: m_fpc, ins: instr});
          m_fpc = m_fpc + 32'd4;
          if (start && q.size() < DEPTH) begin
            m_req  = 1;
            m_addr = m_fpc;
          end
        end
        m_drop = 0;
      end else if (!m_req && start && size_before < DEPTH) begin
        m_req  = 1;
        m_addr = m_fpc;
      end
    end
    if (m_req) m_addr_known = 1;
    else if (redir) m_addr_known = 0;
    if (q.size() != 0) begin
      m_lpc  = q[0].pc;
      m_lins = q[0].ins;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_stall;
`ifdef FETCH_STATS_EN
    exp_stall = m_stall;
`else
    exp_stall = 32'h0;
`endif
    check_val("req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req || m_addr_known) check_val("addr", imem_addr, m_addr);
    check_val("valid", {31'b0, id_valid}, {31'b0, (q.size() != 0)});
    check_val("id_pc", id_pc, m_lpc);
    check_val("id_instr", id_instr, m_lins);
    check_val("id_pc4", id_pc4, m_lpc + 32'd4);
    check_val("stall", stall_cnt, exp_stall);
  endtask

  task automatic run(input int n, input int ps, input int pa, input int pr,
                     input int pd, input int prst);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      compare_all();
      rst   = ($urandom_range(99) < prst);
      start = ($urandom_range(99) < ps);
      rdy   = ($urandom_range(99) < pr);
      redir = ($urandom_range(99) < pd);
      ack   = m_req && ($urandom_range(99) < pa);
      instr = $urandom;
      case ($urandom_range(3))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = 32'h0000_0103;
        2:       rpc = 32'h0000_0040;
        default: rpc = $urandom;
      endcase
      @(posedge clk);
      model_step();
    end
  endtask

  initial begin
    rst   = 1;
    start = 0;
    ack   = 0;
    redir = 0;
    rdy   = 0;
    instr = 0;
    rpc   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", {31'b0, imem_req}, 32'h0);
    check_val("rst_addr", imem_addr, RPC);
    check_val("rst_valid", {31'b0, id_valid}, 32'h0);
    check_val("rst_pc", id_pc, 32'h0);
    check_val("rst_instr", id_instr, 32'h0);
    check_val("rst_pc4", id_pc4, 32'h4);
    check_val("rst_stall", stall_cnt, 32'h0);
    rst = 0;

    // Streaming, then fill to full with decode stalled, then drain.
    run(30,  100, 100, 100, 0,  0);
    run(20,  100, 100, 0,   0,  0);
    run(20,  100, 100, 30,  0,  0);
    // Delayed acks with redirects landing in every state.
    run(600, 90,  40,  50,  10, 0);
    // Redirect-heavy with immediate acks, exercising same-cycle redirect+ack and PC wrap.
    run(400, 100, 90,  70,  25, 0);
    // Start toggling, sporadic resets, idle decode-ready stalls.
    run(600, 50,  50,  60,  8,  2);
    run(40,  0,   100, 100, 0,  0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
